// File: rtl/decode_stage_pipe_pkg.sv
// Shared widths, instruction field positions, opcodes and control decode
// for the pipelined MIPS decode stage.
package decode_stage_pipe_pkg;

   localparam int unsigned DWIDTH_DEF    = 32;
   localparam int unsigned IWIDTH_DEF    = 32;
   localparam int unsigned AWIDTH_DEF    = 5;
   localparam int unsigned IMM_WIDTH_DEF = 16;

   localparam int unsigned OPCODE_WIDTH = 6;
   localparam int unsigned FUNCT_WIDTH  = 6;

   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned FUNCT_LSB  = 0;
   localparam int unsigned IMM_LSB    = 0;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;

   typedef struct packed {
      logic reg_wr;
      logic branch;
      logic alu_src;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic illegal;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [OPCODE_WIDTH-1:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: c.reg_wr = 1'b1;
         OP_LW: begin
            c.alu_src  = 1'b1;
            c.memread  = 1'b1;
            c.memtoreg = 1'b1;
            c.reg_wr   = 1'b1;
         end
         OP_SW: begin
            c.alu_src  = 1'b1;
            c.memwrite = 1'b1;
         end
         OP_BEQ:  c.branch = 1'b1;
         OP_ADDI: begin
            c.alu_src = 1'b1;
            c.reg_wr  = 1'b1;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   // Opcodes whose rt field is a source operand (matters for load-use hazards)
   function automatic logic uses_rt(input logic [OPCODE_WIDTH-1:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile_bypass.sv
// Register file, two combinational read ports with write-through bypass.
// Entry 0 is hardwired to zero.
module regfile_bypass #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned AWIDTH = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wb_en,
   input  logic [AWIDTH-1:0] i_wb_addr,
   input  logic [DWIDTH-1:0] i_wb_data,
   input  logic [AWIDTH-1:0] i_rd_addr_a,
   input  logic [AWIDTH-1:0] i_rd_addr_b,
   output logic [DWIDTH-1:0] o_rd_data_a_c,
   output logic [DWIDTH-1:0] o_rd_data_b_c
);

   localparam int unsigned NREGS = 2 ** AWIDTH;

   logic [DWIDTH-1:0] r_mem [NREGS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      end else if (i_wb_en && (i_wb_addr != '0)) begin
         r_mem[i_wb_addr] <= i_wb_data;
      end
   end

   // Same-cycle writeback is forwarded so decode sees the newest value
   always_comb begin
      o_rd_data_a_c = '0;
      o_rd_data_b_c = '0;
      if (i_rd_addr_a != '0)
         o_rd_data_a_c = (i_wb_en && (i_wb_addr == i_rd_addr_a)) ? i_wb_data : r_mem[i_rd_addr_a];
      if (i_rd_addr_b != '0)
         o_rd_data_b_c = (i_wb_en && (i_wb_addr == i_rd_addr_b)) ? i_wb_data : r_mem[i_rd_addr_b];
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined MIPS decode stage: field/control decode, operand read, load-use
// interlock and a valid/ready ID/EX output register with flush.
module decode_stage_pipe
   import decode_stage_pipe_pkg::*;
#(
   parameter int unsigned DWIDTH    = DWIDTH_DEF,
   parameter int unsigned IWIDTH    = IWIDTH_DEF,
   parameter int unsigned AWIDTH    = AWIDTH_DEF,
   parameter int unsigned IMM_WIDTH = IMM_WIDTH_DEF,
   parameter int unsigned SIGN_EXT  = 1
) (
   input  logic                    dsp_clk,
   input  logic                    dsp_rst,
   input  logic                    dsp_i_valid,
   output logic                    dsp_o_ready,
   input  logic [IWIDTH-1:0]       dsp_i_instr,
   input  logic                    dsp_i_wb_en,
   input  logic [AWIDTH-1:0]       dsp_i_wb_addr,
   input  logic [DWIDTH-1:0]       dsp_i_wb_data,
   input  logic                    dsp_i_flush,
   input  logic                    dsp_i_ready,
   output logic                    dsp_o_valid,
   output logic [OPCODE_WIDTH-1:0] dsp_o_opcode,
   output logic [FUNCT_WIDTH-1:0]  dsp_o_funct,
   output logic [AWIDTH-1:0]       dsp_o_addr_rs,
   output logic [AWIDTH-1:0]       dsp_o_addr_rt,
   output logic [AWIDTH-1:0]       dsp_o_addr_dst,
   output logic [DWIDTH-1:0]       dsp_o_data_rs,
   output logic [DWIDTH-1:0]       dsp_o_data_rt,
   output logic [DWIDTH-1:0]       dsp_o_imm,
   output logic                    dsp_o_reg_wr,
   output logic                    dsp_o_branch,
   output logic                    dsp_o_alu_src,
   output logic                    dsp_o_memread,
   output logic                    dsp_o_memwrite,
   output logic                    dsp_o_memtoreg,
   output logic                    dsp_o_illegal
);

   localparam int unsigned EXT_WIDTH = DWIDTH - IMM_WIDTH;

   logic [OPCODE_WIDTH-1:0] w_opcode;
   logic [FUNCT_WIDTH-1:0]  w_funct;
   logic [AWIDTH-1:0]       w_rs, w_rt, w_rd, w_dst;
   logic [IMM_WIDTH-1:0]    w_imm_raw;
   logic [DWIDTH-1:0]       w_imm, w_data_rs, w_data_rt;
   ctrl_t                   w_ctrl;
   logic                    w_load_en, w_hazard;

   logic                    r_valid;
   logic [OPCODE_WIDTH-1:0] r_opcode;
   logic [FUNCT_WIDTH-1:0]  r_funct;
   logic [AWIDTH-1:0]       r_addr_rs, r_addr_rt, r_addr_dst;
   logic [DWIDTH-1:0]       r_data_rs, r_data_rt, r_imm;
   ctrl_t                   r_ctrl;

   assign w_opcode  = dsp_i_instr[OPCODE_LSB +: OPCODE_WIDTH];
   assign w_funct   = dsp_i_instr[FUNCT_LSB +: FUNCT_WIDTH];
   assign w_rs      = dsp_i_instr[RS_LSB +: AWIDTH];
   assign w_rt      = dsp_i_instr[RT_LSB +: AWIDTH];
   assign w_rd      = dsp_i_instr[RD_LSB +: AWIDTH];
   assign w_imm_raw = dsp_i_instr[IMM_LSB +: IMM_WIDTH];
   assign w_ctrl    = decode_ctrl(w_opcode);
   assign w_dst     = (w_opcode == OP_RTYPE) ? w_rd : w_rt;
   assign w_imm     = (SIGN_EXT != 0) ? {{EXT_WIDTH{w_imm_raw[IMM_WIDTH-1]}}, w_imm_raw}
                                      : {{EXT_WIDTH{1'b0}}, w_imm_raw};

   regfile_bypass #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_regfile (
      .i_clk         (dsp_clk),
      .i_rst         (dsp_rst),
      .i_wb_en       (dsp_i_wb_en),
      .i_wb_addr     (dsp_i_wb_addr),
      .i_wb_data     (dsp_i_wb_data),
      .i_rd_addr_a   (w_rs),
      .i_rd_addr_b   (w_rt),
      .o_rd_data_a_c (w_data_rs),
      .o_rd_data_b_c (w_data_rt)
   );

   // A load in the output register cannot forward to a consumer in decode
   assign w_load_en = !r_valid || dsp_i_ready;
   assign w_hazard  = r_valid && r_ctrl.memread && (r_addr_dst != '0) &&
                      ((r_addr_dst == w_rs) || ((r_addr_dst == w_rt) && uses_rt(w_opcode)));
   assign dsp_o_ready = w_load_en && !w_hazard && !dsp_i_flush;

   // Killed or empty slots carry all-zero controls so they behave as NOPs
   always_ff @(posedge dsp_clk) begin
      if (dsp_rst) begin
         r_valid    <= 1'b0;
         r_opcode   <= '0;
         r_funct    <= '0;
         r_addr_rs  <= '0;
         r_addr_rt  <= '0;
         r_addr_dst <= '0;
         r_data_rs  <= '0;
         r_data_rt  <= '0;
         r_imm      <= '0;
         r_ctrl     <= '0;
      end else if (dsp_i_flush || (w_load_en && w_hazard)) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (w_load_en) begin
         r_valid    <= dsp_i_valid;
         r_opcode   <= w_opcode;
         r_funct    <= w_funct;
         r_addr_rs  <= w_rs;
         r_addr_rt  <= w_rt;
         r_addr_dst <= w_dst;
         r_data_rs  <= w_data_rs;
         r_data_rt  <= w_data_rt;
         r_imm      <= w_imm;
         r_ctrl     <= dsp_i_valid ? w_ctrl : ctrl_t'('0);
      end
   end

   assign dsp_o_valid    = r_valid;
   assign dsp_o_opcode   = r_opcode;
   assign dsp_o_funct    = r_funct;
   assign dsp_o_addr_rs  = r_addr_rs;
   assign dsp_o_addr_rt  = r_addr_rt;
   assign dsp_o_addr_dst = r_addr_dst;
   assign dsp_o_data_rs  = r_data_rs;
   assign dsp_o_data_rt  = r_data_rt;
   assign dsp_o_imm      = r_imm;
   assign dsp_o_reg_wr   = r_ctrl.reg_wr;
   assign dsp_o_branch   = r_ctrl.branch;
   assign dsp_o_alu_src  = r_ctrl.alu_src;
   assign dsp_o_memread  = r_ctrl.memread;
   assign dsp_o_memwrite = r_ctrl.memwrite;
   assign dsp_o_memtoreg = r_ctrl.memtoreg;
   assign dsp_o_illegal  = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: hand-computed expectations checked
// with immediate assertions one cycle after each accepted instruction.
module tb_decode_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        i_ready;
   logic        o_valid;
   logic [5:0]  o_opcode, o_funct;
   logic [4:0]  o_addr_rs, o_addr_rt, o_addr_dst;
   logic [31:0] o_data_rs, o_data_rt, o_imm;
   logic        o_reg_wr, o_branch, o_alu_src, o_memread, o_memwrite, o_memtoreg, o_illegal;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] I_ADD_R3  = 32'h00A01820; // add r3,r5,r0
   localparam logic [31:0] I_ADDI_R8 = 32'h20E8FFFF; // addi r8,r7,-1
   localparam logic [31:0] I_LW_R2   = 32'h8C220004; // lw r2,4(r1)
   localparam logic [31:0] I_ADD_R4  = 32'h00422020; // add r4,r2,r2
   localparam logic [31:0] I_BEQ     = 32'h10220010; // beq r1,r2,0x10
   localparam logic [31:0] I_ADD_R9  = 32'h01200820; // add r1,r9,r0
   localparam logic [31:0] I_ADD_R0  = 32'h00000820; // add r1,r0,r0
   localparam logic [31:0] I_BAD     = 32'hFC000000; // opcode 0x3F

   always #5 clk = ~clk;

   decode_stage_pipe dut (
      .dsp_clk        (clk),
      .dsp_rst        (rst),
      .dsp_i_valid    (i_valid),
      .dsp_o_ready    (o_ready),
      .dsp_i_instr    (i_instr),
      .dsp_i_wb_en    (wb_en),
      .dsp_i_wb_addr  (wb_addr),
      .dsp_i_wb_data  (wb_data),
      .dsp_i_flush    (flush),
      .dsp_i_ready    (i_ready),
      .dsp_o_valid    (o_valid),
      .dsp_o_opcode   (o_opcode),
      .dsp_o_funct    (o_funct),
      .dsp_o_addr_rs  (o_addr_rs),
      .dsp_o_addr_rt  (o_addr_rt),
      .dsp_o_addr_dst (o_addr_dst),
      .dsp_o_data_rs  (o_data_rs),
      .dsp_o_data_rt  (o_data_rt),
      .dsp_o_imm      (o_imm),
      .dsp_o_reg_wr   (o_reg_wr),
      .dsp_o_branch   (o_branch),
      .dsp_o_alu_src  (o_alu_src),
      .dsp_o_memread  (o_memread),
      .dsp_o_memwrite (o_memwrite),
      .dsp_o_memtoreg (o_memtoreg),
      .dsp_o_illegal  (o_illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here too
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_instr = '0; wb_en = 1'b0; wb_addr = '0;
      wb_data = '0; flush = 1'b0; i_ready = 1'b1;
      step(); step();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_reg_wr", 32'(o_reg_wr), 32'd0);
      check("rst_data_rs", o_data_rs, 32'd0);
      rst = 1'b0;

      // Writeback r5, then ADD r3,r5,r0 reads it
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      step();
      wb_en = 1'b0;
      i_valid = 1'b1; i_instr = I_ADD_R3;
      #1 check("add_ready", 32'(o_ready), 32'd1);
      step();
      check("add_valid", 32'(o_valid), 32'd1);
      check("add_data_rs", o_data_rs, 32'h1234);
      check("add_data_rt", o_data_rt, 32'd0);
      check("add_dst", 32'(o_addr_dst), 32'd3);
      check("add_reg_wr", 32'(o_reg_wr), 32'd1);
      check("add_funct", 32'(o_funct), 32'h20);
      check("add_alu_src", 32'(o_alu_src), 32'd0);

      // Same-cycle writeback of r7 bypassed into ADDI
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
      i_instr = I_ADDI_R8;
      step();
      wb_en = 1'b0;
      check("bypass_data_rs", o_data_rs, 32'hDEADBEEF);
      check("addi_imm", o_imm, 32'hFFFFFFFF);
      check("addi_alu_src", 32'(o_alu_src), 32'd1);
      check("addi_dst", 32'(o_addr_dst), 32'd8);
      check("addi_addr_rt", 32'(o_addr_rt), 32'd8);

      // Load-use: LW r2 followed by ADD r4,r2,r2
      i_instr = I_LW_R2;
      step();
      check("lw_memread", 32'(o_memread), 32'd1);
      check("lw_memtoreg", 32'(o_memtoreg), 32'd1);
      check("lw_dst", 32'(o_addr_dst), 32'd2);
      check("lw_imm", o_imm, 32'd4);
      i_instr = I_ADD_R4;
      #1 check("hazard_ready", 32'(o_ready), 32'd0);
      step();
      check("bubble_valid", 32'(o_valid), 32'd0);
      check("bubble_reg_wr", 32'(o_reg_wr), 32'd0);
      check("bubble_memread", 32'(o_memread), 32'd0);
      check("post_bubble_ready", 32'(o_ready), 32'd1);
      step();
      check("use_valid", 32'(o_valid), 32'd1);
      check("use_dst", 32'(o_addr_dst), 32'd4);
      check("use_addr_rs", 32'(o_addr_rs), 32'd2);

      // Back-pressure for 3 cycles with BEQ offered
      i_ready = 1'b0; i_instr = I_BEQ;
      for (int k = 0; k < 3; k++) begin
         #1 check("bp_ready", 32'(o_ready), 32'd0);
         step();
         check("bp_valid", 32'(o_valid), 32'd1);
         check("bp_dst", 32'(o_addr_dst), 32'd4);
         check("bp_opcode", 32'(o_opcode), 32'h00);
      end
      i_ready = 1'b1;
      #1 check("bp_release_ready", 32'(o_ready), 32'd1);
      step();
      check("beq_branch", 32'(o_branch), 32'd1);
      check("beq_reg_wr", 32'(o_reg_wr), 32'd0);
      check("beq_opcode", 32'(o_opcode), 32'h04);
      check("beq_imm", o_imm, 32'h10);
      i_valid = 1'b0;
      step();
      check("no_dup_valid", 32'(o_valid), 32'd0);

      // ADDI again: r7 now read from the array, not the bypass
      i_valid = 1'b1; i_instr = I_ADDI_R8;
      step();
      check("r7_stored", o_data_rs, 32'hDEADBEEF);

      // Flush with a new instruction offered, writeback in the same cycle
      i_instr = I_LW_R2; flush = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
      #1 check("flush_ready", 32'(o_ready), 32'd0);
      step();
      flush = 1'b0; wb_en = 1'b0;
      check("flush_valid", 32'(o_valid), 32'd0);
      check("flush_reg_wr", 32'(o_reg_wr), 32'd0);
      step();
      check("relw_valid", 32'(o_valid), 32'd1);
      check("relw_memread", 32'(o_memread), 32'd1);
      i_instr = I_ADD_R9;
      step();
      check("wb_during_flush", o_data_rs, 32'h55);
      check("r9_valid", 32'(o_valid), 32'd1);

      // Writes to r0 are ignored, including for bypass
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
      i_instr = I_ADD_R0;
      step();
      wb_en = 1'b0;
      check("r0_bypass", o_data_rs, 32'd0);
      step();
      check("r0_read", o_data_rs, 32'd0);

      // Unknown opcode still flows, flagged illegal with no controls
      i_instr = I_BAD;
      step();
      check("bad_valid", 32'(o_valid), 32'd1);
      check("bad_illegal", 32'(o_illegal), 32'd1);
      check("bad_ctrls", 32'({o_reg_wr, o_branch, o_alu_src, o_memread, o_memwrite, o_memtoreg}), 32'd0);

      // SW: memwrite only
      i_instr = 32'hAC220008;
      step();
      check("sw_memwrite", 32'(o_memwrite), 32'd1);
      check("sw_reg_wr", 32'(o_reg_wr), 32'd0);

      // Reset mid-stream
      rst = 1'b1;
      step();
      rst = 1'b0; i_valid = 1'b0;
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_memwrite", 32'(o_memwrite), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
